// File: rtl/ffa_arbiter.sv
// Round-robin arbiter that shares one multi-cycle GF(2^255-19) adder between NREQ requesters.
// Operands are latched on grant and held until the adder finishes or the wait times out.
module ffa_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*255-1:0]   a_i,
  input  logic [NREQ*255-1:0]   b_i,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [254:0]          rsp_data,
  output logic                  err,
  output logic                  busy,
  output logic                  add_start,
  output logic [254:0]          add_a,
  output logic [254:0]          add_b,
  input  logic [254:0]          add_out,
  input  logic                  add_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] owner, ptr, winner, owner_inc;
  logic          found;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;

  // Scan upward from ptr, wrapping modulo NREQ; first set request wins.
  always_comb begin : pick
    logic [IW:0] idx;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (IW+1)'(i);
      if (idx >= (IW+1)'(NREQ))
        idx = idx - (IW+1)'(NREQ);
      if (!found && req[idx[IW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

  assign owner_inc   = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (found) state_nxt = WAIT;
      WAIT: if (add_done || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand registers only load on grant, which keeps them stable for the whole WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= '0;
      ptr       <= '0;
      wait_cnt  <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      err       <= 1'b0;
      add_start <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_data  <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      err       <= 1'b0;
      add_start <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            owner     <= winner;
            add_a     <= a_i[32'(winner)*255 +: 255];
            add_b     <= b_i[32'(winner)*255 +: 255];
            gnt       <= NREQ'(1) << winner;
            add_start <= 1'b1;
            wait_cnt  <= '0;
          end
        end
        WAIT: begin
          if (add_done) begin
            rsp_data  <= add_out;
            rsp_valid <= NREQ'(1) << owner;
            ptr       <= owner_inc;
          end else if (timeout_hit) begin
            err <= 1'b1;
            ptr <= owner_inc;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ffa_arbiter.sv
// Directed and random checks of ffa_arbiter against a 6-cycle field adder model.
module tb_ffa_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 6;
  localparam logic [254:0] P = {255{1'b1}} - 255'd18;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*255-1:0] a_i = '0;
  logic [NREQ*255-1:0] b_i = '0;
  logic [NREQ-1:0]     gnt, rsp_valid;
  logic [254:0]        rsp_data, add_a, add_b;
  logic                err, busy, add_start;
  logic [254:0]        add_out = '0;
  logic                add_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  ffa_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_i(a_i), .b_i(b_i),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err),
    .busy(busy), .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_out(add_out), .add_done(add_done)
  );

  always #5 clk = ~clk;

  // Field adder model: done LAT cycles after add_start, reading operands at the end.
  logic adder_dead = 1'b0;
  int   acnt = 0;
  always @(posedge clk) begin
    logic [255:0] s;
    add_done <= 1'b0;
    if (acnt == 1) begin
      s = {1'b0, add_a} + {1'b0, add_b};
      if (s >= {1'b0, P}) s = s - {1'b0, P};
      add_out  <= s[254:0];
      add_done <= 1'b1;
    end
    if (acnt > 0) acnt <= acnt - 1;
    if (add_start && !adder_dead) acnt <= LAT - 1;
  end

  // Operands must hold from add_start through the end of WAIT.
  bit           stab_en = 1'b0;
  logic [254:0] cap_a, cap_b;
  always @(negedge clk) begin
    if (stab_en) begin
      if (add_start) begin
        cap_a = add_a;
        cap_b = add_b;
      end else if (busy) begin
        n_checks++;
        if (add_a !== cap_a || add_b !== cap_b) begin
          n_fail++;
          $display("FAIL operand_stable got a=%h b=%h exp a=%h b=%h", add_a, add_b, cap_a, cap_b);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [254:0] exp_sum(input logic [254:0] a, input logic [254:0] b);
    logic [256:0] t;
    t = ({2'b0, a} + {2'b0, b}) % {2'b0, P};
    return t[254:0];
  endfunction

  function automatic logic [254:0] rand_fe();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
    if (r[254:0] >= P) return r[254:0] - P;
    return r[254:0];
  endfunction

  task automatic set_ops(input int k, input logic [254:0] a, input logic [254:0] b);
    a_i[k*255 +: 255] = a;
    b_i[k*255 +: 255] = b;
  endtask

  task automatic scramble();
    for (int k = 0; k < NREQ; k++) set_ops(k, rand_fe(), rand_fe());
  endtask

  task automatic do_reset(input logic [NREQ-1:0] req_during);
    req = req_during;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = '1;
    scramble();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({gnt, rsp_valid, err, busy, add_start} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=0", {gnt, rsp_valid, err, busy, add_start});
    end
    n_checks++;
    if (add_a !== '0 || add_b !== '0) begin
      n_fail++;
      $display("FAIL reset_operands got a=%h b=%h exp=0", add_a, add_b);
    end
    n_checks++;
    if (rsp_data !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp_data got=%h exp=0", rsp_data);
    end
    req = '0;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] eg, er;
    do_reset('0);
    scramble();
    set_ops(2, P - 255'd1, 255'd1);
    req = 4'b0100;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) req = '0;
      eg = (c == 1) ? 4'b0100 : 4'b0000;
      er = (c == 8) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (gnt !== eg || add_start !== (c == 1)) begin
        n_fail++;
        $display("FAIL single_gnt c=%0d got gnt=%b start=%b exp gnt=%b", c, gnt, add_start, eg);
      end
      n_checks++;
      if (rsp_valid !== er) begin
        n_fail++;
        $display("FAIL single_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, er);
      end
      if (c == 8) begin
        n_checks++;
        if (rsp_data !== '0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL single_rsp_data got=%h busy=%b exp=0 busy=0", rsp_data, busy);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] eg, er;
    scramble();
    do_reset('1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      eg = (c % 8 == 1) ? NREQ'(1) << (((c - 1) / 8) % 4) : '0;
      er = (c % 8 == 0) ? NREQ'(1) << ((c / 8 - 1) % 4) : '0;
      n_checks++;
      if (gnt !== eg) begin
        n_fail++;
        $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, eg);
      end
      n_checks++;
      if (rsp_valid !== er) begin
        n_fail++;
        $display("FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, er);
      end
    end
    req = '0;
  endtask

  task automatic test_no_preempt();
    logic [NREQ-1:0] eg;
    do_reset('0);
    scramble();
    req = 4'b0001;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) req = 4'b0010;
      eg = (c == 1) ? 4'b0001 : (c == 9) ? 4'b0010 : 4'b0000;
      n_checks++;
      if (gnt !== eg) begin
        n_fail++;
        $display("FAIL nopreempt_gnt c=%0d got=%b exp=%b", c, gnt, eg);
      end
      if (c == 8) begin
        n_checks++;
        if (rsp_valid !== 4'b0001) begin
          n_fail++;
          $display("FAIL nopreempt_rsp got=%b exp=0001", rsp_valid);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_timeout();
    logic [254:0] a, b;
    do_reset('0);
    scramble();
    adder_dead = 1'b1;
    req = 4'b0100;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) req = '0;
      n_checks++;
      if (err !== (c == 17) || busy !== (c <= 16) || rsp_valid !== '0) begin
        n_fail++;
        $display("FAIL timeout c=%0d got err=%b busy=%b rv=%b exp err=%b busy=%b rv=0",
                 c, err, busy, rsp_valid, c == 17, c <= 16);
      end
    end
    adder_dead = 1'b0;
    a = rand_fe();
    b = rand_fe();
    set_ops(3, a, b);
    req = 4'b1100;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req = '0;
        n_checks++;
        if (gnt !== 4'b1000) begin
          n_fail++;
          $display("FAIL timeout_next_gnt got=%b exp=1000", gnt);
        end
      end
    end
    n_checks++;
    if (rsp_valid !== 4'b1000 || rsp_data !== exp_sum(a, b)) begin
      n_fail++;
      $display("FAIL timeout_next_rsp got rv=%b data=%h exp rv=1000 data=%h",
               rsp_valid, rsp_data, exp_sum(a, b));
    end
  endtask

  task automatic test_reset_mid();
    do_reset('0);
    scramble();
    req = 4'b0010;
    repeat (8) @(negedge clk);
    req = 4'b0010;
    for (int c = 9; c <= 12; c++) begin
      @(negedge clk);
      if (c == 9) begin
        req = '0;
        n_checks++;
        if (gnt !== 4'b0010 || add_start !== 1'b1) begin
          n_fail++;
          $display("FAIL rstmid_second_gnt got gnt=%b start=%b exp gnt=0010 start=1", gnt, add_start);
        end
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({gnt, rsp_valid, err, busy, add_start} !== '0 || add_a !== '0 || add_b !== '0 || rsp_data !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got ctrl=%b a=%h b=%h d=%h exp all 0",
               {gnt, rsp_valid, err, busy, add_start}, add_a, add_b, rsp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 13; c <= 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== '0 || busy !== 1'b0 || gnt !== '0) begin
        n_fail++;
        $display("FAIL rstmid_stale c=%0d got rv=%b busy=%b gnt=%b exp 0", c, rsp_valid, busy, gnt);
      end
    end
    req = 4'b1111;
    @(negedge clk);
    req = '0;
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstmid_ptr got=%b exp=0001", gnt);
    end
  endtask

  task automatic test_random();
    logic [254:0] a, b;
    int k, n;
    do_reset('0);
    stab_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0:       begin a = P - 255'd1; b = P - 255'd1; end
        1:       begin a = '0;         b = '0;         end
        2:       begin a = '0;         b = P - 255'd1; end
        3:       begin a = P - 255'd2; b = 255'd1;     end
        default: begin a = rand_fe();  b = rand_fe();  end
      endcase
      k = $urandom_range(0, NREQ - 1);
      scramble();
      set_ops(k, a, b);
      req = NREQ'(1) << k;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (gnt === '0 && n < 4);
      req = '0;
      n_checks++;
      if (gnt !== NREQ'(1) << k) begin
        n_fail++;
        $display("FAIL random_gnt i=%0d got=%b exp=%b", i, gnt, NREQ'(1) << k);
      end
      scramble();
      n = 0;
      while (rsp_valid === '0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      n_checks++;
      if (rsp_valid !== NREQ'(1) << k) begin
        n_fail++;
        $display("FAIL random_rsp_valid i=%0d got=%b exp=%b", i, rsp_valid, NREQ'(1) << k);
      end
      n_checks++;
      if (rsp_data !== exp_sum(a, b)) begin
        n_fail++;
        $display("FAIL random_rsp_data i=%0d got=%h exp=%h", i, rsp_data, exp_sum(a, b));
      end
    end
    stab_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_no_preempt();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ffa_arbiter.md
FFA_ARBITER -- requirements
Module: ffa_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one field adder.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles in WAIT before the operation is abandoned.
REQ-003 Port clk, input, 1: clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port req, input, NREQ: per-requester request level.
REQ-006 Port a_i, input, NREQ*255: requester operand A, slice k = bits [255k+254:255k].
REQ-007 Port b_i, input, NREQ*255: requester operand B, same slicing as a_i.
REQ-008 Port gnt, output, NREQ: one-hot, one-cycle accept pulse.
REQ-009 Port rsp_valid, output, NREQ: one-hot, one-cycle result pulse to the owner.
REQ-010 Port rsp_data, output, 255: result (a+b) mod 2^255-19, meaningful only while rsp_valid is nonzero.
REQ-011 Port err, output, 1: one-cycle timeout pulse.
REQ-012 Port busy, output, 1: high whenever state is not IDLE.
REQ-013 Port add_start, output, 1: one-cycle start pulse to the field adder.
REQ-014 Port add_a / add_b, output, 255 each: adder operands.
REQ-015 Port add_out, input, 255: adder result.
REQ-016 Port add_done, input, 1: adder completion pulse; add_out valid in the same cycle.

Function
REQ-017 The FSM SHALL have exactly the states IDLE and WAIT.
REQ-018 In IDLE with req nonzero, SHALL select the first set req bit scanning upward from ptr, wrapping modulo NREQ.
REQ-019 On that edge it SHALL register the winner index as owner, latch its a_i/b_i slices into add_a/add_b, set gnt[owner]=1 and add_start=1 for the next cycle, and go to WAIT.
REQ-020 add_a/add_b SHALL stay constant from the add_start cycle through the add_done cycle, because the adder reads its operands over several cycles.
REQ-021 In WAIT on add_done=1, SHALL register rsp_data<=add_out, set rsp_valid[owner]=1 for the next cycle, set ptr<=(owner+1) mod NREQ, and go to IDLE.
REQ-022 A 5-bit-or-wider wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without add_done.
REQ-023 When the wait counter reaches TIMEOUT without add_done: pulse err, produce no rsp_valid, set ptr<=(owner+1) mod NREQ, and go to IDLE.
REQ-024 add_done SHALL be ignored in IDLE.
REQ-025 req SHALL be sampled only in IDLE; a requester still holding req on its return to IDLE is treated as a new request.
REQ-026 In the cycle rsp_valid is high the FSM is already in IDLE and SHALL accept a new request; back-to-back service is therefore permitted.
REQ-027 Latency with a 6-cycle adder: req in cycle 0 -> gnt and add_start in cycle 1 -> add_done in cycle 7 -> rsp_valid in cycle 8; worst-case throughput is one operation per 8 cycles.
REQ-028 gnt, rsp_valid, err and add_start SHALL each be high for exactly one cycle per event and SHALL never overlap for different requesters.

Reset
REQ-029 Reset SHALL clear state, owner, ptr, wait counter, gnt, rsp_valid, err, add_start, add_a, add_b and rsp_data to 0, and busy SHALL read 0.
REQ-030 Reset mid-operation SHALL abandon it with no rsp_valid; any later add_done SHALL be ignored as in REQ-024.

Verification
REQ-031 Single request on port 2, a=p-1, b=1 with the real adder -> gnt[2] in cycle 1, rsp_valid[2] in cycle 8, rsp_data=0.
REQ-032 req=4'b1111 held continuously from reset -> grants in order 0,1,2,3,0, each exactly 8 cycles apart.
REQ-033 req[1] rises while port 0 is in WAIT -> no gnt[1] until the cycle after rsp_valid[0].
REQ-034 Adder model never returns done -> err pulses after TIMEOUT WAIT cycles, no rsp_valid, and the next request is serviced normally.
REQ-035 rst asserted 3 cycles after add_start, then released -> all outputs 0, ptr=0, and a stale add_done produces no rsp_valid.
REQ-036 For 1000 random operand pairs across random requesters, rsp_data SHALL equal (a+b) mod 2^255-19 and add_a/add_b SHALL be stable through every WAIT.
